// File: rtl/fcvt_f2i_pipe.sv
`default_nettype none
// =============================================================================
// fcvt_f2i_pipe : pipelined float32 -> int32/uint32 converter (fcvt.w[u].s)
// Revision      : 1.0
// =============================================================================
module fcvt_f2i_pipe #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic             in_unsigned,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_nv,
    output logic             out_nx,
    output logic [TAG_W-1:0] out_tag
);
    localparam int         NRES    = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [2:0] c_RNE   = 3'd0;
    localparam logic [2:0] c_RDN   = 3'd2;
    localparam logic [2:0] c_RUP   = 3'd3;
    localparam logic [2:0] c_RMM   = 3'd4;

    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             big;
        logic             uns;
        logic [2:0]       rm;
        logic [31:0]      ipart;
        logic             g;
        logic             s;
        logic [TAG_W-1:0] tag;
    } sh_t;

    typedef struct packed {
        logic [31:0]      y;
        logic             nv;
        logic             nx;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic        w_adv;
    logic [7:0]  w_exp;
    logic [23:0] w_mant;
    logic [7:0]  w_eunb;
    logic [54:0] w_wide;
    sh_t         w_sh;
    sh_t         w_rin;
    logic        w_rvld;
    logic        w_up;
    logic        w_inx;
    logic [32:0] w_mag;
    res_t        w_res;

    res_t             res_q [NRES];
    logic [NRES-1:0]  vld_q;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Align the significand so the binary point sits between bits 23 and 22.
    assign w_exp  = in_x[30:23];
    assign w_mant = {(w_exp != 8'd0), in_x[22:0]};
    assign w_eunb = w_exp - 8'd127;
    assign w_wide = {31'd0, w_mant} << w_eunb;

    always_comb begin
        w_sh      = '0;
        w_sh.sign = in_x[31];
        w_sh.nan  = (w_exp == 8'hFF) && (in_x[22:0] != 23'd0);
        w_sh.big  = (w_exp >= 8'd159);
        w_sh.uns  = in_unsigned;
        w_sh.rm   = in_rm;
        w_sh.tag  = in_tag;
        if ((w_exp >= 8'd127) && !w_sh.big) begin
            w_sh.ipart = w_wide[54:23];
            w_sh.g     = w_wide[22];
            w_sh.s     = |w_wide[21:0];
        end else if (w_exp == 8'd126) begin
            w_sh.g = w_mant[23];
            w_sh.s = |w_mant[22:0];
        end else if (w_exp < 8'd126) begin
            w_sh.s = |w_mant;
        end
    end

    generate
        if (LATENCY > 1) begin : g_split
            sh_t  sh_q;
            logic sh_vld_q;
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sh_q     <= '0;
                    sh_vld_q <= 1'b0;
                end else if (w_adv) begin
                    sh_q     <= w_sh;
                    sh_vld_q <= in_valid;
                end
            end
            assign w_rin  = sh_q;
            assign w_rvld = sh_vld_q;
        end else begin : g_comb
            assign w_rin  = w_sh;
            assign w_rvld = in_valid;
        end
    endgenerate

    always_comb begin
        w_res = '0;
        w_up  = 1'b0;
        w_inx = w_rin.g | w_rin.s;
        case (w_rin.rm)
            c_RNE:   w_up = w_rin.g & (w_rin.s | w_rin.ipart[0]);
            c_RDN:   w_up = w_rin.sign & w_inx;
            c_RUP:   w_up = ~w_rin.sign & w_inx;
            c_RMM:   w_up = w_rin.g;
            default: w_up = 1'b0;
        endcase
        w_mag     = {1'b0, w_rin.ipart} + {32'd0, w_up};
        w_res.tag = w_rin.tag;
        if (w_rin.nan) begin
            w_res.y  = w_rin.uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            w_res.nv = 1'b1;
        end else if (w_rin.big) begin
            w_res.nv = 1'b1;
            if (w_rin.sign) w_res.y = w_rin.uns ? 32'h0000_0000 : 32'h8000_0000;
            else            w_res.y = w_rin.uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        end else if (w_rin.uns) begin
            // Negative inputs that round to zero are merely inexact.
            if (w_rin.sign) begin
                if (w_mag == 33'd0) w_res.nx = w_inx;
                else                w_res.nv = 1'b1;
            end else if (w_mag[32]) begin
                w_res.y  = 32'hFFFF_FFFF;
                w_res.nv = 1'b1;
            end else begin
                w_res.y  = w_mag[31:0];
                w_res.nx = w_inx;
            end
        end else begin
            if (w_rin.sign) begin
                if (w_mag > 33'h0_8000_0000) begin
                    w_res.y  = 32'h8000_0000;
                    w_res.nv = 1'b1;
                end else begin
                    w_res.y  = 32'd0 - w_mag[31:0];
                    w_res.nx = w_inx;
                end
            end else if (w_mag > 33'h0_7FFF_FFFF) begin
                w_res.y  = 32'h7FFF_FFFF;
                w_res.nv = 1'b1;
            end else begin
                w_res.y  = w_mag[31:0];
                w_res.nx = w_inx;
            end
        end
        if (!w_rvld) w_res = '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NRES; k++) res_q[k] <= '0;
            vld_q <= '0;
        end else if (w_adv) begin
            res_q[0] <= w_res;
            vld_q[0] <= w_rvld;
            for (int k = 1; k < NRES; k++) begin
                res_q[k] <= res_q[k-1];
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign out_valid = vld_q[NRES-1];
    assign out_y     = res_q[NRES-1].y;
    assign out_nv    = res_q[NRES-1].nv;
    assign out_nx    = res_q[NRES-1].nx;
    assign out_tag   = res_q[NRES-1].tag;

endmodule
`default_nettype wire

// File: tb/tb_fcvt_f2i_pipe.sv
`default_nettype none
// =============================================================================
// tb_fcvt_f2i_pipe : directed self-checking bench for fcvt_f2i_pipe
// Revision         : 1.0
// =============================================================================
module tb_fcvt_f2i_pipe;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_x = '0;
    logic             in_unsigned = 1'b0;
    logic [2:0]       in_rm = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_y;
    logic             out_nv;
    logic             out_nx;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bp_x [6];
    int          bp_acc;
    int          bp_cons;
    int          bp_cyc [6];

    always #5 clk = ~clk;

    fcvt_f2i_pipe #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_unsigned (in_unsigned),
        .in_rm       (in_rm),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_nv      (out_nv),
        .out_nx      (out_nx),
        .out_tag     (out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic convert(input string name, input logic [31:0] x, input logic uns,
                           input logic [2:0] rm, input logic [31:0] ey, input logic env,
                           input logic enx, input logic [TAG_W-1:0] tag);
        bit got;
        got = 1'b0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_x        = x;
        in_unsigned = uns;
        in_rm       = rm;
        in_tag      = tag;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            got      = out_valid;
        end
        if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
        else check(name, {25'd0, out_tag, out_nv, out_nx, out_y}, {25'd0, tag, env, enx, ey});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {24'd0, out_valid, out_nv, out_nx, out_tag, out_y}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        convert("pos2p5_rne", 32'h40200000, 1'b0, 3'd0, 32'h00000002, 1'b0, 1'b1, 5'd1);
        convert("pos2p5_rmm", 32'h40200000, 1'b0, 3'd4, 32'h00000003, 1'b0, 1'b1, 5'd2);
        convert("pos2p5_rup", 32'h40200000, 1'b0, 3'd3, 32'h00000003, 1'b0, 1'b1, 5'd3);
        convert("pos2p5_rdn", 32'h40200000, 1'b0, 3'd2, 32'h00000002, 1'b0, 1'b1, 5'd4);
        convert("pos2p5_rtz", 32'h40200000, 1'b0, 3'd1, 32'h00000002, 1'b0, 1'b1, 5'd5);
        convert("pos2p5_rm7", 32'h40200000, 1'b0, 3'd7, 32'h00000002, 1'b0, 1'b1, 5'd6);
        convert("neg2p5_rne", 32'hC0200000, 1'b0, 3'd0, 32'hFFFFFFFE, 1'b0, 1'b1, 5'd7);
        convert("neg2p5_rdn", 32'hC0200000, 1'b0, 3'd2, 32'hFFFFFFFD, 1'b0, 1'b1, 5'd8);
        convert("neg2p5_rup", 32'hC0200000, 1'b0, 3'd3, 32'hFFFFFFFE, 1'b0, 1'b1, 5'd9);
        convert("p2e31_s",    32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 5'd10);
        convert("p2e31_u",    32'h4F000000, 1'b1, 3'd0, 32'h80000000, 1'b0, 1'b0, 5'd11);
        convert("n2e31_s",    32'hCF000000, 1'b0, 3'd0, 32'h80000000, 1'b0, 1'b0, 5'd12);
        convert("p2e32_u",    32'h4F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd13);
        convert("nan_s",      32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 5'd14);
        convert("nan_u",      32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd15);
        convert("ninf_s",     32'hFF800000, 1'b0, 3'd0, 32'h80000000, 1'b1, 1'b0, 5'd16);
        convert("ninf_u",     32'hFF800000, 1'b1, 3'd0, 32'h00000000, 1'b1, 1'b0, 5'd17);
        convert("pinf_u",     32'h7F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd18);
        convert("neg0p3_u",   32'hBE99999A, 1'b1, 3'd1, 32'h00000000, 1'b0, 1'b1, 5'd19);
        convert("neg1_u",     32'hBF800000, 1'b1, 3'd0, 32'h00000000, 1'b1, 1'b0, 5'd20);
        convert("neg0p5_u",   32'hBF000000, 1'b1, 3'd0, 32'h00000000, 1'b0, 1'b1, 5'd21);
        convert("denorm_rup", 32'h00000001, 1'b0, 3'd3, 32'h00000001, 1'b0, 1'b1, 5'd22);
        convert("negzero",    32'h80000000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 5'd23);
        convert("half_rne",   32'h3F000000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b1, 5'd24);
        convert("onep5_rne",  32'h3FC00000, 1'b0, 3'd0, 32'h00000002, 1'b0, 1'b1, 5'd25);
        convert("big_exact",  32'h4EFFFFFF, 1'b0, 3'd0, 32'h7FFFFF80, 1'b0, 1'b0, 5'd26);

        // Backpressure: tags 1..6 carry the values 1.0..6.0, consumer stalls in cycles 3-7.
        bp_x[0] = 32'h3F800000; bp_x[1] = 32'h40000000; bp_x[2] = 32'h40400000;
        bp_x[3] = 32'h40800000; bp_x[4] = 32'h40A00000; bp_x[5] = 32'h40C00000;
        bp_acc  = 0;
        bp_cons = 0;
        @(negedge clk);
        for (int c = 0; c < 40 && bp_cons < 6; c++) begin
            @(negedge clk);
            out_ready   = !(c >= 3 && c <= 7);
            in_valid    = (bp_acc < 6);
            in_unsigned = 1'b0;
            in_rm       = 3'd0;
            if (bp_acc < 6) begin
                in_x   = bp_x[bp_acc];
                in_tag = TAG_W'(bp_acc + 1);
            end
            #1;
            if (out_valid && !out_ready) check("bp_stall_ready", {63'd0, in_ready}, 64'd0);
            if (out_valid)
                check("bp_result", {25'd0, out_tag, out_nv, out_nx, out_y},
                      {25'd0, TAG_W'(bp_cons + 1), 2'b00, 32'(bp_cons + 1)});
            if (out_valid && out_ready) begin
                bp_cyc[bp_cons] = c;
                bp_cons++;
            end
            if (in_valid && in_ready) bp_acc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(bp_cons), 64'd6);
        for (int i = 2; i < 6; i++) check("bp_rate", 64'(bp_cyc[i] - bp_cyc[i-1]), 64'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_drain", {63'd0, out_valid}, 64'd0);
        end

        // Reset with two ops in flight; the consumer holds off so neither is taken.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 32'h3F800000;
        in_tag    = 5'd20;
        @(negedge clk);
        in_x      = 32'h40000000;
        in_tag    = 5'd21;
        @(negedge clk);
        rstn      = 1'b0;
        in_x      = 32'h40400000;
        in_tag    = 5'd22;
        @(posedge clk);
        #1;
        check("rst_mid_clear", {24'd0, out_valid, out_nv, out_nx, out_tag, out_y}, 64'd0);
        @(negedge clk);
        rstn      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("rst_no_ghost", {63'd0, out_valid}, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 32'h40A00000;
        in_tag   = 5'd23;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_lat_edge1", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_lat_edge2", {26'd0, out_valid, out_tag, out_y}, {26'd0, 1'b1, 5'd23, 32'd5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fcvt_f2i_pipe.md
Name: fcvt_f2i_pipe

Overview:
Pipelined, parametrised float32-to-integer converter: the successor to the combinational fcvtws. It implements both RISC-V conversions, fcvt.w.s (signed) and fcvt.wu.s (unsigned), under all five rounding modes, and produces IEEE exception flags. It adds a valid/ready handshake with full backpressure and a sideband tag, so it can sit directly in the FPU issue/writeback path.

Parameters:
LATENCY, 2, register stages from input acceptance to out_valid (legal 1..4); conversion logic is split across the stages.
TAG_W, 5, width of the sideband tag (destination register index) carried alongside each operation.

Ports:
clk  in  1  clock; all state updates on rising edge.
rstn  in  1  synchronous active-low reset.
in_valid  in  1  operation offered.
in_ready  out  1  converter accepts the operation this cycle.
in_x  in  32  IEEE-754 single-precision operand.
in_unsigned  in  1  0 = fcvt.w.s, 1 = fcvt.wu.s.
in_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 behave as RTZ.
in_tag  in  TAG_W  sideband, returned unchanged.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts the result.
out_y  out  32  integer result.
out_nv  out  1  invalid-operation flag.
out_nx  out  1  inexact flag.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (rstn=0 at a clock edge): all stage valid bits clear; out_valid=0, out_y=0, out_nv=0, out_nx=0, out_tag=0. Reset mid-operation discards every in-flight op; no partial result ever appears. in_ready may be 1 during reset, but nothing is captured.
- Pipeline control: advance = !out_valid || out_ready; in_ready = advance. When advance=1, every stage shifts one position. When advance=0, all stages hold, including data and flags.
- Transfer rules: an op is accepted iff in_valid && in_ready at an edge. A result is consumed iff out_valid && out_ready. Results emerge strictly in acceptance order.
- Latency and throughput: with out_ready held high, an op accepted at edge N has out_valid=1 after edge N+LATENCY−1 and is consumed at edge N+LATENCY. Throughput is one op per cycle. Bubbles propagate as invalid stages.
- Output hold: outputs stay stable while out_valid && !out_ready.
- Arithmetic:
  - Unbiased exponent e = exp−127; the significand includes the hidden bit (denormals have no hidden bit and are always |x|<1).
  - Shift to a 32-bit integer magnitude plus guard/round/sticky bits.
  - Round per rm using sign and LSB. RMM rounds ties away from zero. RDN/RUP are directional, on the sign.
  - Apply the sign (two's complement) after rounding.
- Flag rules: NX=1 iff any discarded bit is nonzero and the result is not saturated-invalid. NV and NX are never both set.
- Signed saturation: a rounded value > 2^31−1 gives 0x7FFFFFFF with NV; a value < −2^31 gives 0x80000000 with NV. Exactly −2^31 is exact, with no flag.
- Unsigned saturation: a rounded value > 2^32−1 gives 0xFFFFFFFF with NV. A negative input whose rounded result is 0 gives 0 with NX only. A negative input whose rounded result is ≤ −1 gives 0 with NV.
- NaN (either kind): 0x7FFFFFFF signed or 0xFFFFFFFF unsigned, with NV. +inf saturates to max with NV; −inf saturates to min (0 for unsigned) with NV.
- ±0 and zero-rounded denormals: result 0, flags 0 for ±0, NX for a nonzero denormal.
- Large exponents: e ≥ 32 always saturates, so no shift amount ever exceeds the datapath.

Test Plan:
- Rounding, positive: 2.5 (0x40200000), signed. rm=RNE → 0x00000002 with NX; RMM → 0x00000003 with NX; RUP → 0x00000003; RDN → 0x00000002; RTZ → 0x00000002.
- Rounding, negative: −2.5 (0xC0200000), signed. RNE → 0xFFFFFFFE with NX; RDN → 0xFFFFFFFD; RUP → 0xFFFFFFFE.
- Signed/unsigned boundaries:
  - 0x4F000000 (2^31): signed → 0x7FFFFFFF with NV; unsigned → 0x80000000, no flags.
  - 0xCF000000: signed → 0x80000000, no flags.
  - 0x4F800000 (2^32): unsigned → 0xFFFFFFFF with NV.
- Special values: 0x7FC00000 (NaN) signed → 0x7FFFFFFF with NV. 0xFF800000 (−inf) signed → 0x80000000 with NV. Unsigned −0.3 (0xBE99999A) RTZ → 0 with NX only; unsigned −1.0 (0xBF800000) → 0 with NV. 0x00000001 RUP signed → 0x00000001 with NX.
- Backpressure, LATENCY=2: stream tags 1..6 with out_ready low for cycles 3–7. Required:
  - in_ready=0 whenever out_valid && !out_ready;
  - all 6 results delivered once each, in order, with tags intact;
  - outputs stable while stalled;
  - with out_ready high, back-to-back acceptance gives 1 result/cycle.
- Reset mid-stream: rstn=0 for one edge while 2 ops are in flight. Required: out_valid=0 and outputs zero the next cycle; neither op is ever emitted. The first op accepted after reset appears LATENCY edges later.
